// File: rtl/sample_store.sv
// sample_store: circular buffer of 32-bit time-series samples.
// The producer appends samples at wr_ptr. The iterator reads by logical index,
// where index 0 is the oldest retained sample. Read data is registered and
// arrives one cycle after the request.
//
// Optional build macro SAMPLE_STORE_NO_OVERWRITE_EN:
//   defined   - a write while full is discarded and wr_drop pulses on the next cycle
//   undefined - a write while full overwrites the oldest sample; wr_drop is tied 0
module sample_store #(
  parameter  int DEPTH = 16,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          Clk,
  input  logic          Rst,
  input  logic          wr_en,
  input  logic [31:0]   wr_data,
  input  logic          clear,
  input  logic          rd_en,
  input  logic [31:0]   rd_index,
  output logic [31:0]   rd_value,
  output logic          rd_valid,
  output logic          rd_err,
  output logic [AW:0]   count,
  output logic          empty,
  output logic          full,
  output logic          wr_drop
);

  localparam logic [AW-1:0] PTR_ONE   = 1;
  localparam logic [AW:0]   CNT_ONE   = 1;
  localparam logic [AW:0]   CNT_DEPTH = DEPTH[AW:0];

  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] oldest;
  logic [AW-1:0] rd_addr;
  logic          rd_in_range;
  logic          wr_accept;

  assign empty = (count == '0);
  assign full  = (count == CNT_DEPTH);

  // The oldest slot sits count entries behind wr_ptr. When full, count[AW-1:0]
  // is zero, so oldest lands on wr_ptr without a special case.
  assign oldest  = wr_ptr - count[AW-1:0];
  assign rd_addr = oldest + rd_index[AW-1:0];

  // The range check uses every bit of rd_index, so a huge index whose low bits
  // alias a valid slot is still rejected.
  assign rd_in_range = (rd_index < 32'(count));

`ifdef SAMPLE_STORE_NO_OVERWRITE_EN
  assign wr_accept = wr_en && !clear && !full;

  // Flag a write that arrived while the window was full and was discarded.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      wr_drop <= 1'b0;
    end else begin
      wr_drop <= wr_en && !clear && full;
    end
  end
`else
  assign wr_accept = wr_en && !clear;
  assign wr_drop   = 1'b0;
`endif

  // Sample storage. Writes use the pre-edge wr_ptr, and a read on the same edge
  // still sees the old contents.
  // NOTE: the memory array has no reset. Its contents are don't-care until
  // they are written, and omitting the reset lets it map onto RAM.
  always_ff @(posedge Clk) begin
    if (wr_accept) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // Write pointer and occupancy. clear takes priority over a write in the same cycle.
  // NOTE: state registers use non-blocking assignments only. This keeps
  // every same-edge read (for example the rd_addr lookup) on pre-edge values.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      wr_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      count  <= '0;
    end else if (wr_accept) begin
      wr_ptr <= wr_ptr + PTR_ONE;
      if (!full) begin
        count <= count + CNT_ONE;
      end
    end
  end

  // Registered read response with one-cycle latency. rd_value holds its
  // previous value on an error or when no read is requested.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      rd_value <= '0;
      rd_valid <= 1'b0;
      rd_err   <= 1'b0;
    end else begin
      rd_valid <= rd_en && rd_in_range;
      rd_err   <= rd_en && !rd_in_range;
      if (rd_en && rd_in_range) begin
        rd_value <= mem[rd_addr];
      end
    end
  end

endmodule

// File: tb/tb_sample_store.sv
// Testbench for sample_store (DEPTH = 8), built on a scoreboard.
// The reference model keeps the logical window as a queue, with the oldest
// sample at the front. Read expectations are queued when a request is driven
// and popped when the DUT answers.
module tb_sample_store;

  localparam int DEPTH = 8;
  localparam int AW    = $clog2(DEPTH);

  logic          Clk;
  logic          Rst;
  logic          wr_en;
  logic [31:0]   wr_data;
  logic          clear;
  logic          rd_en;
  logic [31:0]   rd_index;
  logic [31:0]   rd_value;
  logic          rd_valid;
  logic          rd_err;
  logic [AW:0]   count;
  logic          empty;
  logic          full;
  logic          wr_drop;

  sample_store #(.DEPTH(DEPTH)) dut (
    .Clk      (Clk),
    .Rst      (Rst),
    .wr_en    (wr_en),
    .wr_data  (wr_data),
    .clear    (clear),
    .rd_en    (rd_en),
    .rd_index (rd_index),
    .rd_value (rd_value),
    .rd_valid (rd_valid),
    .rd_err   (rd_err),
    .count    (count),
    .empty    (empty),
    .full     (full),
    .wr_drop  (wr_drop)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct {
    logic        err;
    logic [31:0] value;
  } rd_exp_t;

  rd_exp_t     sb[$];
  logic [31:0] win[$];
  logic [31:0] last_value;
  int          errors;
  int          checks;
  int          drop_seen;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%08h) expected %0d (0x%08h) at %0t",
               tag, got, got, exp, exp, $time);
    end
  endtask

  // One clock cycle of stimulus. The model is updated against pre-edge state,
  // and the registered outputs are checked after the edge.
  task automatic step(input logic wr, input logic [31:0] wd, input logic clr,
                      input logic rd, input logic [31:0] idx);
    logic    exp_drop;
    rd_exp_t e;
    wr_en    = wr;
    wr_data  = wd;
    clear    = clr;
    rd_en    = rd;
    rd_index = idx;
    if (rd) begin
      if (idx < 32'(win.size())) begin
        last_value = win[idx];
        e.err = 1'b0;
      end else begin
        e.err = 1'b1;
      end
      e.value = last_value;
      sb.push_back(e);
    end
    exp_drop = 1'b0;
    if (clr) begin
      win.delete();
    end else if (wr) begin
      if (win.size() == DEPTH) begin
`ifdef SAMPLE_STORE_NO_OVERWRITE_EN
        exp_drop = 1'b1;
`else
        void'(win.pop_front());
        win.push_back(wd);
`endif
      end else begin
        win.push_back(wd);
      end
    end
    @(posedge Clk);
    @(negedge Clk);
    #1;
    if (wr_drop) drop_seen++;
    check("count",   32'(count),   32'(win.size()));
    check("empty",   32'(empty),   32'(win.size() == 0));
    check("full",    32'(full),    32'(win.size() == DEPTH));
    check("wr_drop", 32'(wr_drop), 32'(exp_drop));
    if (rd) check("rd_response_seen", 32'(sb.size()), 32'd0);
  endtask

  task automatic idle();
    step(1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
  endtask

  task automatic wr(input logic [31:0] d);
    step(1'b1, d, 1'b0, 1'b0, 32'd0);
  endtask

  task automatic rd(input logic [31:0] idx);
    step(1'b0, 32'd0, 1'b0, 1'b1, idx);
  endtask

  // Response monitor: every rd_valid or rd_err pulse consumes one scoreboard entry.
  always @(negedge Clk) begin
    if (Rst && (rd_valid || rd_err)) begin
      if (sb.size() == 0) begin
        check("rd_spurious", 32'd1, 32'd0);
      end else begin
        rd_exp_t e;
        e = sb.pop_front();
        check("rd_err",   32'(rd_err),   32'(e.err));
        check("rd_valid", 32'(rd_valid), 32'(!e.err));
        check("rd_value", rd_value,      e.value);
      end
    end
  end

  initial begin
    errors     = 0;
    checks     = 0;
    drop_seen  = 0;
    last_value = '0;
    Rst      = 1'b0;
    wr_en    = 1'b0;
    wr_data  = '0;
    clear    = 1'b0;
    rd_en    = 1'b0;
    rd_index = '0;
    repeat (3) @(negedge Clk);
    Rst = 1'b1;

    // 1: reset state, then a read of an empty buffer
    check("rst_count",    32'(count),    32'd0);
    check("rst_empty",    32'(empty),    32'd1);
    check("rst_full",     32'(full),     32'd0);
    check("rst_rd_value", rd_value,      32'd0);
    check("rst_rd_valid", 32'(rd_valid), 32'd0);
    rd(0);
    check("empty_rd_value", rd_value, 32'd0);

    // 2: three samples read back-to-back, then out-of-range indices
    wr(10); wr(20); wr(30);
    rd(0); rd(1); rd(2); rd(3);
    rd(32'h0000_0100);
    rd(32'h8000_0001);
    idle();

    // 3: ten writes into eight slots
    step(1'b0, 0, 1'b1, 1'b0, 0);
    drop_seen = 0;
    for (int i = 1; i <= 10; i++) wr(i);
    rd(0); rd(7); rd(8);
`ifdef SAMPLE_STORE_NO_OVERWRITE_EN
    check("drop_pulses", 32'(drop_seen), 32'd2);
    check("t3_oldest", win[0], 32'd1);
`else
    check("drop_pulses", 32'(drop_seen), 32'd0);
    check("t3_oldest", win[0], 32'd3);
`endif

    // 4: write and read in the same cycle on a full buffer
    step(1'b1, 11, 1'b0, 1'b1, 0);
    rd(0);
    idle();

    // 5: clear together with a write, then clear together with a read
    step(1'b0, 0, 1'b1, 1'b0, 0);
    for (int i = 0; i < 5; i++) wr(50 + i);
    step(1'b1, 99, 1'b1, 1'b0, 0);
    rd(0);
    wr(7);
    rd(0);
    wr(8);
    step(1'b0, 0, 1'b1, 1'b1, 1);
    rd(0);

    // Random traffic
    for (int n = 0; n < 400; n++) begin
      logic        w, c, r;
      logic [31:0] idx;
      w   = ($urandom_range(0, 99) < 55);
      c   = ($urandom_range(0, 99) < 4);
      r   = ($urandom_range(0, 99) < 60);
      idx = ($urandom_range(0, 19) == 0) ? $urandom : 32'($urandom_range(0, DEPTH + 1));
      step(w, $urandom, c, r, idx);
    end
    idle();

    // 6: asynchronous reset between a read edge and its response sample
    step(1'b0, 0, 1'b1, 1'b0, 0);
    wr(32'h1234_5678);
    rd_en    = 1'b1;
    rd_index = 0;
    @(posedge Clk);
    #2 Rst = 1'b0;
    #1;
    check("arst_rd_valid", 32'(rd_valid), 32'd0);
    check("arst_rd_err",   32'(rd_err),   32'd0);
    check("arst_rd_value", rd_value,      32'd0);
    rd_en = 1'b0;
    win.delete();
    last_value = '0;
    #4 Rst = 1'b1;
    idle();
    check("post_rst_rd_value", rd_value, 32'd0);
    rd(0);

    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
